// File: rtl/crc32_stream.sv
// crc32_stream: reflected IEEE 802.3 CRC-32 over a byte-keyed valid/ready stream.
// MODE=1 appends the FCS to every frame; MODE=0 passes frames through and flags a bad FCS.
module crc32_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = 0,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_tkeep_o,
  output logic                  m_tlast_o,
  output logic                  m_tuser_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [31:0]           crc_o,
  output logic                  crc_valid_o
);
  localparam int          N           = KEEP_WIDTH;
  localparam int          SPILL_SHIFT = (N < 4) ? 8 * N : 0;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [0:0]  ST_DATA     = 1'b0;
  localparam logic [0:0]  ST_SPILL    = 1'b1;

  // Handshake: a beat moves on a side when its valid and ready are both high at the rising edge.
  logic [0:0]            r_state;
  logic                  r_run;
  logic [31:0]           r_crc;
  logic [31:0]           r_spill;
  logic [2:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;
  logic                  r_tlast;
  logic                  r_tuser;
  logic                  r_tvalid;
  logic [31:0]           r_crc_out;
  logic                  r_crc_valid;

  logic [31:0]            w_crc_next;
  logic [31:0]            w_fcs;
  logic [3:0]             w_k;
  logic [DATA_WIDTH-1:0]  w_data_masked;
  logic [DATA_WIDTH+31:0] w_pack;
  logic [KEEP_WIDTH-1:0]  w_keep_fcs;
  logic [KEEP_WIDTH-1:0]  w_keep_spill;
  logic [DATA_WIDTH-1:0]  w_spill_data;
  logic [3:0]             w_spill_n;
  logic                   w_fits;
  logic                   w_s_fire;
  logic                   w_m_fire;
  logic                   w_spill_done;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      x = (x >> 1) ^ (32'hEDB88320 & {32{x[0]}});
    end
    return x;
  endfunction

  always_comb begin
    w_crc_next    = r_crc;
    w_k           = 4'd0;
    w_data_masked = '0;
    for (int i = 0; i < N; i++) begin
      if (s_tkeep_i[i]) begin
        w_crc_next              = crc_byte(w_crc_next, s_tdata_i[8*i +: 8]);
        w_k                     = w_k + 4'd1;
        w_data_masked[8*i +: 8] = s_tdata_i[8*i +: 8];
      end
    end
  end

  // Last-beat data followed by the FCS; bytes past N are what spills into extra beats.
  assign w_fcs  = ~w_crc_next;
  assign w_pack = ({{DATA_WIDTH{1'b0}}, w_fcs} << {w_k, 3'b000}) | {32'h0, w_data_masked};
  assign w_fits = (w_k + 4'd4) <= 4'(N);

  assign w_spill_n    = ({1'b0, r_cnt} > 4'(N)) ? 4'(N) : {1'b0, r_cnt};
  assign w_spill_data = DATA_WIDTH'(r_spill);
  assign w_spill_done = (r_cnt == 3'd0);

  always_comb begin
    w_keep_fcs   = '0;
    w_keep_spill = '0;
    for (int i = 0; i < N; i++) begin
      w_keep_fcs[i]   = 4'(i) < (w_k + 4'd4);
      w_keep_spill[i] = 4'(i) < w_spill_n;
    end
  end

  assign s_tready_o = r_run && (r_state == ST_DATA) && (!r_tvalid || m_tready_i);
  assign w_s_fire   = s_tvalid_i && s_tready_o;
  assign w_m_fire   = r_tvalid && m_tready_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= ST_DATA;
      r_run       <= 1'b0;
      r_crc       <= CRC_INIT;
      r_spill     <= 32'h0;
      r_cnt       <= 3'd0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_crc_out   <= 32'h0;
      r_crc_valid <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_crc_valid <= 1'b0;
      if (w_s_fire) begin
        r_tvalid <= 1'b1;
        r_tdata  <= s_tdata_i;
        r_tkeep  <= s_tkeep_i;
        r_tlast  <= s_tlast_i;
        r_tuser  <= 1'b0;
        r_crc    <= w_crc_next;
        if (s_tlast_i) begin
          r_crc       <= CRC_INIT;
          r_crc_out   <= w_fcs;
          r_crc_valid <= 1'b1;
          if (MODE == 0) begin
            r_tuser <= (w_crc_next != CRC_RESIDUE);
          end else begin
            r_tdata <= w_pack[DATA_WIDTH-1:0];
            if (w_fits) begin
              r_tkeep <= w_keep_fcs;
            end else begin
              r_tkeep <= '1;
              r_tlast <= 1'b0;
              r_spill <= w_pack[DATA_WIDTH +: 32];
              r_cnt   <= 3'(w_k + 4'd4 - 4'(N));
              r_state <= ST_SPILL;
            end
          end
        end
      end else if (r_state == ST_SPILL) begin
        // r_cnt reaches zero once the final spill beat is loaded; leave only after it is taken.
        if (w_m_fire) begin
          if (w_spill_done) begin
            r_state  <= ST_DATA;
            r_tvalid <= 1'b0;
          end else begin
            r_tdata <= w_spill_data;
            r_tkeep <= w_keep_spill;
            r_tlast <= ({1'b0, r_cnt} <= 4'(N));
            r_spill <= r_spill >> SPILL_SHIFT;
            r_cnt   <= r_cnt - 3'(w_spill_n);
          end
        end
      end else if (w_m_fire) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_tdata_o   = r_tdata;
  assign m_tkeep_o   = r_tkeep;
  assign m_tlast_o   = r_tlast;
  assign m_tuser_o   = r_tuser;
  assign m_tvalid_o  = r_tvalid;
  assign crc_o       = r_crc_out;
  assign crc_valid_o = r_crc_valid;

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: GEN at widths 8/16/32/64 and CHK at 16/64, each against a
// table-driven CRC model with a queue scoreboard, random backpressure and a mid-frame reset.
module tb_crc32_stream;
  localparam int NI = 6;
  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  bit          go;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] tbl[256];
  logic        all_part;
  logic        all_fin;

  function automatic void chk(input string name, input int inst,
                              input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", name, inst, act, exp);
    end
  endfunction

  // c_final of the frame (before inversion), table-driven.
  function automatic logic [31:0] crc_res(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = tbl[8'(c ^ 32'(b[i]))] ^ (c >> 8);
    return c;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int DW = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 32 : (g == 4) ? 16 : 64;
    localparam int MD = (g < 4) ? 1 : 0;
    localparam int N  = DW / 8;

    logic [DW-1:0]    s_tdata;
    logic [N-1:0]     s_tkeep;
    logic             s_tlast;
    logic             s_tvalid;
    logic             s_tready;
    logic [DW-1:0]    m_tdata;
    logic [N-1:0]     m_tkeep;
    logic             m_tlast;
    logic             m_tuser;
    logic             m_tvalid;
    logic             m_tready;
    logic [31:0]      crc;
    logic             crc_valid;
    bit               rnd = 0;
    bit               part_done = 0;
    bit               fin = 0;
    logic [DW+N+1:0]  exp_q[$];
    logic [31:0]      crc_q[$];

    crc32_stream #(.DATA_WIDTH(DW), .MODE(MD)) dut (
      .clk_i(clk), .arstn_i(arstn),
      .s_tdata_i(s_tdata), .s_tkeep_i(s_tkeep), .s_tlast_i(s_tlast),
      .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
      .m_tdata_o(m_tdata), .m_tkeep_o(m_tkeep), .m_tlast_o(m_tlast),
      .m_tuser_o(m_tuser), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
      .crc_o(crc), .crc_valid_o(crc_valid)
    );

    task automatic rst_check(input string nm);
      chk({nm, "_data"}, g, 64'(m_tdata), 64'h0);
      chk({nm, "_ctrl"}, g, 64'({s_tready, m_tkeep, m_tlast, m_tuser, m_tvalid, crc_valid}), 64'h0);
      chk({nm, "_crc"}, g, 64'(crc), 64'h0);
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
      int t;
      t = 0;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!s_tready) chk("s_tready_timeout", g, 64'h0, 64'h1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input bit ovr, input logic [31:0] ovr_crc, input bit gaps);
      bq_t           o;
      logic [31:0]   res;
      int            nb;
      logic [DW-1:0] d;
      logic [N-1:0]  k;
      logic          u;
      logic [DW-1:0] din[$];
      logic [N-1:0]  kin[$];
      res = crc_res(f);
      nb  = (f.size() + N - 1) / N;
      for (int b = 0; b < nb; b++) begin
        d = DW'({$urandom(), $urandom()});
        k = '0;
        for (int i = 0; i < N; i++) begin
          if (b * N + i < f.size()) begin
            d[8*i +: 8] = f[b*N+i];
            k[i] = 1'b1;
          end
        end
        din.push_back(d);
        kin.push_back(k);
      end
      crc_q.push_back(ovr ? ovr_crc : ~res);
      if (MD == 1) begin
        o = f;
        for (int i = 0; i < 4; i++) o.push_back(8'((~res) >> (8 * i)));
        nb = (o.size() + N - 1) / N;
        for (int b = 0; b < nb; b++) begin
          d = '0;
          k = '0;
          for (int i = 0; i < N; i++) begin
            if (b * N + i < o.size()) begin
              d[8*i +: 8] = o[b*N+i];
              k[i] = 1'b1;
            end
          end
          exp_q.push_back({d, k, 1'(b == nb - 1), 1'b0});
        end
      end else begin
        for (int b = 0; b < din.size(); b++) begin
          u = (b == din.size() - 1) && (res != 32'hDEBB20E3);
          exp_q.push_back({din[b], kin[b], 1'(b == din.size() - 1), u});
        end
      end
      for (int b = 0; b < din.size(); b++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        drive_beat(din[b], kin[b], 1'(b == din.size() - 1));
      end
    endtask

    initial begin
      m_tready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end

    initial begin
      bq_t  f;
      int   len;
      int   t;
      int   idx;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
      @(negedge clk);
      rst_check("reset");
      wait (arstn === 1'b1);
      @(posedge clk);
      #1;
      drive_beat(DW'({$urandom(), $urandom()}), '1, 1'b0);
      part_done = 1;
      @(negedge arstn);
      #1;
      rst_check("midframe_reset");
      wait (go);
      @(posedge clk);
      #1;
      f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      if (MD == 1) begin
        send_frame(f, 1'b1, 32'hCBF43926, 1'b0);
        if (DW == 64) begin
          f = {};
          for (int i = 0; i < 12; i++) f.push_back(8'($urandom()));
          send_frame(f, 1'b0, 32'h0, 1'b0);
        end
      end else begin
        f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
        send_frame(f, 1'b1, 32'h2144DF1C, 1'b0);
        f[3] = f[3] ^ 8'h01;
        send_frame(f, 1'b0, 32'h0, 1'b0);
      end
      rnd = 1;
      for (int n = 0; n < 200; n++) begin
        f = {};
        len = $urandom_range(1, 40);
        for (int i = 0; i < len; i++) f.push_back(8'($urandom()));
        if (MD == 0) begin
          logic [31:0] fcs;
          fcs = ~crc_res(f);
          for (int i = 0; i < 4; i++) f.push_back(8'(fcs >> (8 * i)));
          if ($urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, f.size() - 1);
            f[idx] = f[idx] ^ 8'(1 << $urandom_range(0, 7));
          end
        end
        send_frame(f, 1'b0, 32'h0, 1'b1);
      end
      rnd = 0;
      t = 0;
      while ((exp_q.size() != 0 || crc_q.size() != 0) && t < 2000) begin
        @(posedge clk);
        t++;
      end
      chk("exp_q_left", g, 64'(exp_q.size()), 64'h0);
      chk("crc_q_left", g, 64'(crc_q.size()), 64'h0);
      fin = 1;
    end

    initial begin
      logic [DW+N+1:0] e;
      logic [DW+N+1:0] cur;
      logic [DW+N+1:0] held;
      logic [DW-1:0]   mask;
      logic [N-1:0]    ek;
      logic            stall;
      stall = 1'b0;
      held  = '0;
      forever begin
        @(negedge clk);
        if (go) begin
          cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
          if (stall) begin
            chk("stall_valid", g, 64'(m_tvalid), 64'h1);
            chk("stall_hold", g, 64'(cur[DW+N+1:N+2]), 64'(held[DW+N+1:N+2]));
          end
          stall = m_tvalid && !m_tready;
          held  = cur;
          if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
              chk("extra_beat", g, 64'h1, 64'h0);
            end else begin
              e  = exp_q.pop_front();
              ek = e[N+1:2];
              for (int i = 0; i < N; i++) mask[8*i +: 8] = (MD == 0 || ek[i]) ? 8'hFF : 8'h00;
              chk("beat_data", g, 64'(m_tdata & mask), 64'(e[DW+N+1:N+2] & mask));
              chk("beat_ctrl", g, 64'({m_tkeep, m_tlast, m_tuser}), 64'(e[N+1:0]));
            end
          end
          if (crc_valid) begin
            if (crc_q.size() == 0) chk("extra_crc_valid", g, 64'h1, 64'h0);
            else chk("crc_o", g, 64'(crc), 64'(crc_q.pop_front()));
          end
        end
      end
    end
  end

  assign all_part = u[0].part_done & u[1].part_done & u[2].part_done &
                    u[3].part_done & u[4].part_done & u[5].part_done;
  assign all_fin  = u[0].fin & u[1].fin & u[2].fin & u[3].fin & u[4].fin & u[5].fin;

  initial begin
    int t;
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      repeat (8) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      tbl[n] = c;
    end
    go    = 1'b0;
    arstn = 1'b0;
    repeat (3) @(posedge clk);
    #3 arstn = 1'b1;
    t = 0;
    while (!all_part && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (!all_part) chk("partial_frame_timeout", -1, 64'h0, 64'h1);
    @(posedge clk);
    #3 arstn = 1'b0;
    repeat (3) @(posedge clk);
    #3 arstn = 1'b1;
    @(posedge clk);
    #1 go = 1'b1;
    t = 0;
    while (!all_fin && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (!all_fin) chk("run_timeout", -1, 64'h0, 64'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
